// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR with runtime Fibonacci/Galois selection,
// seed load, all-zero lock-up recovery and period measurement.
// Everything is registered on clk; rst is synchronous and active-high.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FTAPS = 8'hB8,
  parameter logic [WIDTH-1:0] GPOLY = 8'h71,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_vld
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;

  // Candidate next states for both LFSR forms; mode picks one per step.
  always_comb begin
    fib_fb    = ^(state_q & FTAPS);
    fib_next  = {state_q[WIDTH-2:0], fib_fb};
    gal_next  = {state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & GPOLY);
    step_next = mode ? gal_next : fib_next;
  end

  // Next-state decode: load beats step; a zero state or zero seed is
  // replaced by SEED and flagged with a lockup pulse instead of a wrap.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    wrap_d       = 1'b0;
    lockup_d     = 1'b0;
    if (load) begin
      if (seed_in == '0) begin
        state_d  = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = seed_in;
        start_d  = seed_in;
      end
      cnt_d        = '0;
      period_vld_d = 1'b0;
    end else if (en) begin
      if (state_q == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = step_next;
        cnt_d   = cnt_q + ONE;
        if (step_next == start_q) begin
          wrap_d       = 1'b1;
          period_d     = cnt_q + ONE;
          period_vld_d = 1'b1;
          cnt_d        = '0;
        end
      end
    end
  end

  // State registers with synchronous reset; a reset discards any measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEED;
      start_q      <= SEED;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      wrap_q       <= 1'b0;
      lockup_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      wrap_q       <= wrap_d;
      lockup_q     <= lockup_d;
    end
  end

  assign out        = state_q;
  assign bit_out    = state_q[WIDTH-1];
  assign wrap       = wrap_q;
  assign lockup     = lockup_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen (WIDTH=4, FTAPS=C, GPOLY=9, SEED=1).
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] seed_in = 4'h0;
  logic [3:0] out;
  logic       bit_out;
  logic       wrap;
  logic       lockup;
  logic [3:0] period;
  logic       period_vld;

  lfsr_gen #(.WIDTH(4), .FTAPS(4'hC), .GPOLY(4'h9), .SEED(4'h1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .seed_in(seed_in), .out(out), .bit_out(bit_out), .wrap(wrap),
    .lockup(lockup), .period(period), .period_vld(period_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] out;
    logic       wrap;
    logic       lockup;
    logic [3:0] period;
    logic       vld;
    int         sc;
    int         step;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   n_total = 0;
  int   n_pass  = 0;
  int   sc      = 0;
  int   step    = 0;

  // Hand-computed orbits of x^4+x^3+1 starting at 1.
  logic [3:0] FIB [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] GAL [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7,
                           4'hE, 4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC};

  // Bench-side bookkeeping for start/count/period.
  logic [3:0] m_out = 4'h1, m_start = 4'h1, m_cnt = 4'h0, m_per = 4'h0;
  logic       m_vld = 1'b0, m_wrap = 1'b0, m_lock = 1'b0;

  function automatic logic [3:0] fib_next(input logic [3:0] v);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 15; i++) if (FIB[i] == v) r = FIB[(i + 1) % 15];
    return r;
  endfunction

  function automatic logic [3:0] gal_next(input logic [3:0] v);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 15; i++) if (GAL[i] == v) r = GAL[(i + 1) % 15];
    return r;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic md, input logic ld,
                     input logic [3:0] sd, input logic [3:0] nx);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = md; load = ld; seed_in = sd;
    m_wrap = 1'b0;
    m_lock = 1'b0;
    if (r) begin
      m_out = 4'h1; m_start = 4'h1; m_cnt = 4'h0; m_per = 4'h0; m_vld = 1'b0;
    end else if (ld) begin
      if (sd == 4'h0) begin
        m_out = 4'h1; m_start = 4'h1; m_lock = 1'b1;
      end else begin
        m_out = sd; m_start = sd;
      end
      m_cnt = 4'h0;
      m_vld = 1'b0;
    end else if (e) begin
      m_out = nx;
      m_cnt = m_cnt + 4'h1;
      if (m_out == m_start) begin
        m_wrap = 1'b1; m_per = m_cnt; m_vld = 1'b1; m_cnt = 4'h0;
      end
    end
    step++;
    x.out = m_out; x.wrap = m_wrap; x.lockup = m_lock;
    x.period = m_per; x.vld = m_vld; x.sc = sc; x.step = step;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask
  task automatic step_fib();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, fib_next(m_out));
  endtask
  task automatic step_gal();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, gal_next(m_out));
  endtask
  task automatic hold();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  // Monitor: outputs settle after each posedge; compare against the queue head.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      n_total++;
      if (out !== mx.out || bit_out !== mx.out[3] || wrap !== mx.wrap ||
          lockup !== mx.lockup || period !== mx.period || period_vld !== mx.vld) begin
        $display("FAIL sc%0d step%0d: got out=%h bit=%b wrap=%b lockup=%b period=%h vld=%b; want out=%h bit=%b wrap=%b lockup=%b period=%h vld=%b",
                 mx.sc, mx.step, out, bit_out, wrap, lockup, period, period_vld,
                 mx.out, mx.out[3], mx.wrap, mx.lockup, mx.period, mx.vld);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    int guard;
    // 1: Fibonacci full orbit, wrap on return to 1, period 15
    sc = 1; step = 0;
    do_reset();
    for (int i = 0; i < 15; i++) step_fib();
    hold();

    // 2: Galois full orbit, period 15
    sc = 2; step = 0;
    do_reset();
    for (int i = 0; i < 15; i++) step_gal();
    hold();

    // 3: zero seed -> SEED + lockup; load beats en; orbit from 6
    sc = 3; step = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 4'h0);
    for (int i = 0; i < 15; i++) step_fib();
    hold();

    // 4: en 1,0,0,1 -> out 2,2,2,4
    sc = 4; step = 0;
    do_reset();
    step_fib();
    hold();
    hold();
    step_fib();

    // 5: three Fibonacci steps (9), then Galois (B) until back at 1; period 14
    sc = 5; step = 0;
    do_reset();
    for (int i = 0; i < 3; i++) step_fib();
    guard = 0;
    do begin
      step_gal();
      guard++;
    end while (m_out != 4'h1 && guard < 20);
    hold();

    // 6: after a valid measurement, reset mid-run clears it
    sc = 6; step = 0;
    do_reset();
    for (int i = 0; i < 15; i++) step_fib();
    for (int i = 0; i < 5; i++) step_fib();
    do_reset();
    hold();

    repeat (3) @(negedge clk);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised maximal-length pseudo-random sequence generator. It is the generalised successor of the team's fixed 8-bit LFSR.
- Width, tap set and seed are configurable.
- Fibonacci or Galois form is selectable at runtime.
- Adds step enable, seed load, all-zero lock-up recovery, and period measurement (wrap detect plus step count).
- Feeds scramblers, BIST pattern generators and test stimulus in the datapath.

Parameters:
- WIDTH, 8, state/output width; legal range 3..32.
- FTAPS, 8'hB8, Fibonacci tap mask. Bit i set means state bit i is XORed into the feedback. Default is x^8+x^6+x^5+x^4+1.
- GPOLY, 8'h71, Galois mask: the lower polynomial coefficients, bit 0 = x^0. Default is the same polynomial.
- SEED, 8'h01, reset and recovery value. Must be non-zero; elaboration error if zero.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance one step per cycle while high.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on every step.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  value to load.
- out  out  WIDTH  current state (registered).
- bit_out  out  1  out[WIDTH-1], serial stream bit.
- wrap  out  1  one-cycle pulse: state has returned to start value.
- lockup  out  1  one-cycle pulse: zero state/seed replaced by SEED.
- period  out  WIDTH  steps between start and last wrap.
- period_vld  out  1  period holds a valid measurement.

Behaviour:
- Reset is synchronous and active-high; one clock, no other clock domains.
- Reset values: out = SEED, internal start = SEED, step count cnt = 0, wrap = 0, lockup = 0, period = 0, period_vld = 0.
- Fibonacci next state: fb = XOR over i of (s[i] & FTAPS[i]); next = {s[WIDTH-2:0], fb}.
- Galois next state: next = {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & GPOLY).
- Priority is rst > load > en.
- Load:
  - state <= seed_in and start <= seed_in; cnt <= 0; period_vld <= 0; period is held.
  - Load acts regardless of en.
  - If seed_in == 0: state and start <= SEED instead, and lockup pulses in the following cycle.
- Step (en = 1, load = 0):
  - Guard: if state == 0, state <= SEED, lockup pulses, cnt is unchanged.
  - Otherwise state <= next(mode) and cnt <= cnt + 1, modulo 2^WIDTH.
  - If next == start: wrap = 1 in the following cycle, period <= cnt + 1, period_vld <= 1, cnt <= 0.
- Latency: every state change and pulse is visible one cycle after the sampling edge. wrap is high exactly in the cycle in which out == start.
- Hold (en = 0, load = 0): state, cnt, period and start are held; wrap and lockup are 0.
- Mode switch mid-run is legal; start and cnt carry over. wrap still fires only when the state equals start.
- Pulses never last more than one cycle; wrap and lockup are never both high.
- A non-maximal tap set is legal. The period is whatever the sequence yields, and it fits in WIDTH bits because any non-zero LFSR orbit has at most 2^WIDTH - 1 states.
- Reset mid-sequence discards the measurement: period_vld = 0 and period = 0.

Test Plan:
All scenarios use WIDTH=4, FTAPS=4'hC, GPOLY=4'h9, SEED=4'h1.
1. Reset, then en=1, mode=0 for 15 cycles -> out = 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1. wrap is high only on the cycle out returns to 1. Then period = 15 and period_vld = 1.
2. Reset, en=1, mode=1 -> out = 1,2,4,8,9,B,F,7,E,5,A,D,3,6,C,1. wrap on the return to 1; period = 15.
3. load=1 with seed_in=0 -> next cycle out = 1, lockup = 1 for one cycle, period_vld = 0. Then load=1, en=1, seed_in=6 -> out = 6 (load wins). After 15 Fibonacci steps out = 6, wrap = 1, period = 15.
4. en toggled 1,0,0,1 from reset with mode=0 -> out = 2,2,2,4. No wrap or lockup pulses.
5. mode=0 for 3 steps (out = 9), then mode=1 for 1 step -> out = B. Run until out == 1 -> wrap fires then. period equals the total step count, checked against the model.
6. Reach period_vld = 1 (scenario 1), run 5 more steps, assert rst for one cycle -> out = 1, period = 0, period_vld = 0, wrap = 0.
